sa_pe_mosa_multibank: RTL
=========================

# sa_pe_mosa_multibank

Parametrised successor to the MOSA-style systolic processing element. It moves activations and weights to neighbouring PEs, runs an opcode-driven signed integer multiply-accumulate, and supports a configurable multiply pipeline depth. It holds N_ACC independent accumulator banks and drains results through a valid/ready result FIFO, so the array can interleave several output tiles per PE and stall on downstream backpressure.

## Interface
- IA_W, 16, activation width (signed)
- IB_W, 16, weight/immediate width (signed)
- ACC_W, 40, accumulator and result width; must be ≥ IA_W+IB_W
- N_ACC, 4, number of accumulator banks; must be ≥ 2
- MUL_STAGES, 1, extra multiply pipeline registers (≥ 0)
- FIFO_DEPTH, 2, result FIFO entries (≥ 1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipeline_en  in  1  global stall: 0 freezes propagation and MAC pipeline
- a  in  IA_W  activation from neighbour
- b  in  IB_W  weight from neighbour
- imm  in  IB_W  immediate operand
- op_valid  in  1  op offered
- op_ready  out  1  op accepted when op_valid && op_ready
- op  in  3  opcode
- bank  in  $clog2(N_ACC)  target accumulator bank
- a_out  out  IA_W  registered a
- b_out  out  IB_W  registered b
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer ready
- res_data  out  ACC_W  drained accumulator value
- res_bank  out  $clog2(N_ACC)  bank the value came from

## Operation
- Opcodes: 0 NOP; 1 MAC acc[bank] += a*b; 2 MUL acc[bank] = a*b; 3 MACI acc[bank] += a*imm; 4 CLR acc[bank] = 0; 5 DRAIN push acc[bank] into FIFO, then zero the bank; 6, 7 treated as NOP.
- Operands a, b, imm are sampled at acceptance.
- Product: full signed IA_W×IB_W, sign-extended to ACC_W.
- Sum: wraps modulo 2^ACC_W (see Configuration).
- Pipeline: L = MUL_STAGES+1 stages. Opcode, bank, and operands travel together.
- All bank reads and writes happen only in the final stage, in acceptance order. Back-to-back ops on the same bank therefore need no hazard logic.
- Credit counter = FIFO occupancy + DRAINs in flight.
- op_ready = pipeline_en && !(credit == FIFO_DEPTH && op == DRAIN). Non-DRAIN ops are never blocked by the FIFO.
- Credit behaviour:
  - +1 when a DRAIN is accepted.
  - −1 when a FIFO pop happens (res_valid && res_ready).
  - An accept and a pop in the same cycle leave credit unchanged.
- The FIFO can never overflow.
- Propagation: when pipeline_en = 1, a_out/b_out load a/b every cycle, independent of op_valid.

## Timing
- Reset: all banks, stage registers, a_out, b_out, res_data, and res_bank are 0. res_valid = 0, FIFO empty, credit 0. op_ready = pipeline_en in the first cycle after rst deasserts.
- Reset mid-operation: in-flight ops and FIFO contents are discarded with no completion.
- Accept at edge E0 → bank update (or FIFO push) at edge E_L, assuming pipeline_en stays 1.
- DRAIN latency: result is visible (res_valid = 1) in the cycle after E_L.
- While pipeline_en = 0:
  - Stage registers and banks hold.
  - No accepts.
  - FIFO pops continue.
- res_data and res_bank are stable while res_valid && !res_ready.
- A push and a pop in the same cycle are allowed at any occupancy, including full.
- DRAIN immediately following a MAC on the same bank drains the post-MAC value.
- DRAIN on a bank followed next cycle by MAC on that bank: the MAC starts from 0.

## Configuration
- SA_PE_SAT_EN defined: MAC/MACI/MUL results clamp to the signed ACC_W range, i.e. [−2^(ACC_W−1), 2^(ACC_W−1)−1].
- A sticky per-bank overflow flag is set on clamping and cleared by CLR/DRAIN. It is exposed as res_data's bank flag via an extra port res_sat (1 bit, FIFO-carried, resets to 0).
- Undefined: results wrap modulo 2^ACC_W, and the res_sat port is absent.

## Test plan
- Reset, then MAC bank0 a=3 b=4 three times, then DRAIN bank0 → res_data=36, res_bank=0 exactly L+1 cycles after the DRAIN is accepted; bank0 then reads 0.
- Interleave MAC bank1 (a=−2, b=5) and MACI bank2 (a=7, imm=−1) ×4 each, then DRAIN both → bank1=−40, bank2=−28, delivered in DRAIN order.
- Hold res_ready=0 and issue FIFO_DEPTH+1 DRAINs → op_ready drops on the extra DRAIN while MACs are still accepted. Raise res_ready → the extra DRAIN is accepted and the stalled data stays stable.
- pipeline_en=0 for 5 cycles mid-MAC stream → a_out/b_out hold, no accepts, and final sums are identical to the unstalled run.
- With SA_PE_SAT_EN, ACC_W=32: MAC a=32767 b=32767 ×3 → res_data=2147483647, res_sat=1. Without the macro, the same stimulus gives wrapped value −1073938429.
- Assert rst with 2 DRAINs in flight and 1 in the FIFO → res_valid=0 next cycle, no late pushes, all banks 0.

Source files
------------

// File: rtl/sa_pe_mosa_multibank.sv
`default_nettype none
// ============================================================================
// Module      : sa_pe_mosa_multibank
// Description : Systolic PE with neighbour propagation of a/b, an opcode
//               driven signed MAC pipeline (MUL_STAGES+1 stages), N_ACC
//               accumulator banks and a credit-protected valid/ready result
//               FIFO. Optional macro SA_PE_SAT_EN enables saturating
//               accumulation and adds the FIFO-carried res_sat flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_pe_mosa_multibank #(
  parameter int IA_W       = 16,
  parameter int IB_W       = 16,
  parameter int ACC_W      = 40,
  parameter int N_ACC      = 4,
  parameter int MUL_STAGES = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipeline_en,
  input  logic [IA_W-1:0]          a,
  input  logic [IB_W-1:0]          b,
  input  logic [IB_W-1:0]          imm,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [2:0]               op,
  input  logic [$clog2(N_ACC)-1:0] bank,
  output logic [IA_W-1:0]          a_out,
  output logic [IB_W-1:0]          b_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ACC_W-1:0]         res_data,
  output logic [$clog2(N_ACC)-1:0] res_bank
`ifdef SA_PE_SAT_EN
  ,
  output logic                     res_sat
`endif
);

  localparam int c_BANK_W = $clog2(N_ACC);
  localparam int c_L      = MUL_STAGES + 1;
  localparam int c_P_W    = IA_W + IB_W;
  localparam int c_CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [2:0] c_OP_MAC   = 3'd1;
  localparam logic [2:0] c_OP_MUL   = 3'd2;
  localparam logic [2:0] c_OP_MACI  = 3'd3;
  localparam logic [2:0] c_OP_CLR   = 3'd4;
  localparam logic [2:0] c_OP_DRAIN = 3'd5;

`ifdef SA_PE_SAT_EN
  localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  // Operand pipeline: product, opcode and bank travel together.
  logic                r_vld  [c_L];
  logic [2:0]          r_op   [c_L];
  logic [c_BANK_W-1:0] r_bank [c_L];
  logic [ACC_W-1:0]    r_prod [c_L];

  logic [ACC_W-1:0]    r_acc [N_ACC];
`ifdef SA_PE_SAT_EN
  logic                r_ovf [N_ACC];
  logic                r_fifo_sat [FIFO_DEPTH];
`endif

  logic [ACC_W-1:0]    r_fifo_data [FIFO_DEPTH];
  logic [c_BANK_W-1:0] r_fifo_bank [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CRED_W-1:0] r_count;
  logic [c_CRED_W-1:0] r_credit;

  logic                    w_accept;
  logic                    w_drain_acc;
  logic [IB_W-1:0]         w_opb;
  logic signed [c_P_W-1:0] w_prod;
  logic [ACC_W-1:0]        w_prod_ext;
  logic                    w_f_vld;
  logic [2:0]              w_f_op;
  logic [c_BANK_W-1:0]     w_f_bank;
  logic [ACC_W-1:0]        w_f_prod;
  logic [ACC_W-1:0]        w_cur;
  logic [ACC_W:0]          w_sum;
  logic                    w_ovf;
  logic [ACC_W-1:0]        w_acc_next;
  logic                    w_push;
  logic                    w_pop;
  logic [c_PTR_W-1:0]      w_wr_ptr_nxt;
  logic [c_PTR_W-1:0]      w_rd_ptr_nxt;

  // A DRAIN is refused only when every FIFO slot is already promised.
  assign op_ready    = pipeline_en && !((r_credit == c_CRED_W'(FIFO_DEPTH)) && (op == c_OP_DRAIN));
  assign w_accept    = op_valid && op_ready;
  assign w_drain_acc = w_accept && (op == c_OP_DRAIN);

  // Full-precision signed product, sign-extended to the accumulator width.
  assign w_opb      = (op == c_OP_MACI) ? imm : b;
  assign w_prod     = c_P_W'($signed(a)) * c_P_W'($signed(w_opb));
  assign w_prod_ext = ACC_W'(w_prod);

  // Final stage: the only place banks are read or written.
  assign w_f_vld  = r_vld[c_L-1] && pipeline_en;
  assign w_f_op   = r_op[c_L-1];
  assign w_f_bank = r_bank[c_L-1];
  assign w_f_prod = r_prod[c_L-1];
  assign w_cur    = r_acc[w_f_bank];
  assign w_sum    = {w_cur[ACC_W-1], w_cur} + {w_f_prod[ACC_W-1], w_f_prod};
  assign w_ovf    = w_sum[ACC_W] ^ w_sum[ACC_W-1];
`ifdef SA_PE_SAT_EN
  assign w_acc_next = w_ovf ? (w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX) : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  assign w_push = w_f_vld && (w_f_op == c_OP_DRAIN);
  assign w_pop  = res_valid && res_ready;

  assign w_wr_ptr_nxt = (r_wr_ptr == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);

  assign res_valid = (r_count != '0);
  assign res_data  = r_fifo_data[r_rd_ptr];
  assign res_bank  = r_fifo_bank[r_rd_ptr];
`ifdef SA_PE_SAT_EN
  assign res_sat   = r_fifo_sat[r_rd_ptr];
`endif

  // Neighbour propagation, frozen by the global stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
    end else if (pipeline_en) begin
      a_out <= a;
      b_out <= b;
    end
  end

  // MAC pipeline shift; stage 0 captures the accepted op, bubbles otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_L; i++) begin
        r_vld[i]  <= 1'b0;
        r_op[i]   <= '0;
        r_bank[i] <= '0;
        r_prod[i] <= '0;
      end
    end else if (pipeline_en) begin
      r_vld[0]  <= w_accept;
      r_op[0]   <= op;
      r_bank[0] <= bank;
      r_prod[0] <= w_prod_ext;
      for (int i = 1; i < c_L; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_op[i]   <= r_op[i-1];
        r_bank[i] <= r_bank[i-1];
        r_prod[i] <= r_prod[i-1];
      end
    end
  end

  // Accumulator bank update from the final pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ACC; i++) begin
        r_acc[i] <= '0;
`ifdef SA_PE_SAT_EN
        r_ovf[i] <= 1'b0;
`endif
      end
    end else if (w_f_vld) begin
      case (w_f_op)
        c_OP_MAC, c_OP_MACI: begin
          r_acc[w_f_bank] <= w_acc_next;
`ifdef SA_PE_SAT_EN
          if (w_ovf) r_ovf[w_f_bank] <= 1'b1;
`endif
        end
        c_OP_MUL: r_acc[w_f_bank] <= w_f_prod;
        c_OP_CLR, c_OP_DRAIN: begin
          r_acc[w_f_bank] <= '0;
`ifdef SA_PE_SAT_EN
          r_ovf[w_f_bank] <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Result FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_bank[i] <= '0;
`ifdef SA_PE_SAT_EN
        r_fifo_sat[i]  <= 1'b0;
`endif
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_cur;
        r_fifo_bank[r_wr_ptr] <= w_f_bank;
`ifdef SA_PE_SAT_EN
        r_fifo_sat[r_wr_ptr]  <= r_ovf[w_f_bank];
`endif
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop) r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CRED_W'(1);
        2'b01:   r_count <= r_count - c_CRED_W'(1);
        default: ;
      endcase
    end
  end

  // Credits: FIFO occupancy plus DRAINs still travelling down the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit <= '0;
    end else begin
      case ({w_drain_acc, w_pop})
        2'b10:   r_credit <= r_credit + c_CRED_W'(1);
        2'b01:   r_credit <= r_credit - c_CRED_W'(1);
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
